// File: rtl/simple_ram_bist.sv
// simple_ram_bist: built-in self-test initiator for a single-port synchronous RAM.
//
// On a START pulse (sampled only while idle or finished) it sweeps every address four times:
// write P(a), read-verify P(a), write ~P(a), read-verify ~P(a), where
// P(a) = SEED[DATAW-1:0] ^ a. Each read phase is followed by one drain cycle that compares
// the final read still in flight.
//
// Ports:
//   CLK, RST           clock (rising edge) and asynchronous active-high reset
//   START              begin test (ignored while BUSY)
//   BUSY/DONE/PASS     status; DONE and PASS hold until the next START or RST
//   ERRCNT             saturating count of mismatching reads
//   FADDR/FDATA        address and read data of the first mismatch
//   M_WEN/M_CEN/M_ADDR/M_DATi   RAM command outputs (all registered)
//   M_DATo             RAM read data, valid one cycle after the read address was presented
module simple_ram_bist #(
    parameter int unsigned DATAW = 32,
    parameter int unsigned DEPTH = 2**14,
    parameter logic [31:0] SEED  = 32'hA5A5_5A5A,
    parameter int unsigned ERRW  = 16,
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [ERRW-1:0]  ERRCNT,
    output logic [AW-1:0]    FADDR,
    output logic [DATAW-1:0] FDATA,
    output logic             M_WEN,
    output logic             M_CEN,
    output logic [AW-1:0]    M_ADDR,
    output logic [DATAW-1:0] M_DATi,
    input  logic [DATAW-1:0] M_DATo
);

    typedef enum logic [2:0] {
        StIdle, StWr0, StRd0, StDrn0, StWr1, StRd1, StDrn1, StFin
    } state_t;

    localparam logic [AW-1:0]   LastAddr = AW'(DEPTH - 1);
    localparam logic [ERRW-1:0] ErrMax   = '1;

    function automatic logic [DATAW-1:0] pattern(input logic [AW-1:0] a, input logic inv);
        logic [DATAW-1:0] p;
        p = DATAW'(SEED) ^ DATAW'(a);
        return inv ? ~p : p;
    endfunction

    state_t           state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             wen_q, wen_d;
    logic             cen_q, cen_d;
    logic [DATAW-1:0] dati_q, dati_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [ERRW-1:0]  errcnt_q, errcnt_d;
    logic [AW-1:0]    faddr_q, faddr_d;
    logic [DATAW-1:0] fdata_q, fdata_d;
    logic             found_q, found_d;
    // Read pipeline: the read presented this cycle is compared when its data returns.
    logic             pv_q, pv_d;
    logic [AW-1:0]    pa_q, pa_d;
    logic [DATAW-1:0] pe_q, pe_d;

    logic clear;
    logic last;
    logic mism;
    logic wr_next;
    logic rd_next;

    assign last = (addr_q == LastAddr);
    assign mism = pv_q && (M_DATo != pe_q);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        clear   = 1'b0;
        unique case (state_q)
            StIdle, StFin: begin
                if (START) begin
                    state_d = StWr0;
                    addr_d  = '0;
                    clear   = 1'b1;
                end
            end
            StWr0: begin
                addr_d = last ? '0 : addr_q + AW'(1);
                if (last) state_d = StRd0;
            end
            StRd0: begin
                addr_d = last ? '0 : addr_q + AW'(1);
                if (last) state_d = StDrn0;
            end
            StDrn0: begin
                state_d = StWr1;
                addr_d  = '0;
            end
            StWr1: begin
                addr_d = last ? '0 : addr_q + AW'(1);
                if (last) state_d = StRd1;
            end
            StRd1: begin
                addr_d = last ? '0 : addr_q + AW'(1);
                if (last) state_d = StDrn1;
            end
            StDrn1: begin
                state_d = StFin;
                addr_d  = '0;
            end
            default: state_d = StIdle;
        endcase

        // Registered RAM command for the cycle after this edge.
        wr_next = (state_d == StWr0) || (state_d == StWr1);
        rd_next = (state_d == StRd0) || (state_d == StRd1);
        cen_d   = wr_next || rd_next;
        wen_d   = wr_next;
        dati_d  = wr_next ? pattern(addr_d, state_d == StWr1) : '0;
        busy_d  = (state_d != StIdle) && (state_d != StFin);

        pv_d = (state_q == StRd0) || (state_q == StRd1);
        pa_d = addr_q;
        pe_d = pattern(addr_q, state_q == StRd1);

        errcnt_d = errcnt_q;
        faddr_d  = faddr_q;
        fdata_d  = fdata_q;
        found_d  = found_q;
        if (clear) begin
            errcnt_d = '0;
            faddr_d  = '0;
            fdata_d  = '0;
            found_d  = 1'b0;
        end else if (mism) begin
            if (errcnt_q != ErrMax) errcnt_d = errcnt_q + ERRW'(1);
            if (!found_q) begin
                found_d = 1'b1;
                faddr_d = pa_q;
                fdata_d = M_DATo;
            end
        end

        // Uses the next error count so the final drain compare is reflected in PASS.
        done_d = (state_d == StFin);
        pass_d = done_d && (errcnt_d == '0);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            wen_q    <= 1'b0;
            cen_q    <= 1'b0;
            dati_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            errcnt_q <= '0;
            faddr_q  <= '0;
            fdata_q  <= '0;
            found_q  <= 1'b0;
            pv_q     <= 1'b0;
            pa_q     <= '0;
            pe_q     <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wen_q    <= wen_d;
            cen_q    <= cen_d;
            dati_q   <= dati_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            errcnt_q <= errcnt_d;
            faddr_q  <= faddr_d;
            fdata_q  <= fdata_d;
            found_q  <= found_d;
            pv_q     <= pv_d;
            pa_q     <= pa_d;
            pe_q     <= pe_d;
        end
    end

    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign PASS   = pass_q;
    assign ERRCNT = errcnt_q;
    assign FADDR  = faddr_q;
    assign FDATA  = fdata_q;
    assign M_WEN  = wen_q;
    assign M_CEN  = cen_q;
    assign M_ADDR = addr_q;
    assign M_DATi = dati_q;

endmodule

// File: tb/tb_simple_ram_bist.sv
// Scoreboard bench for simple_ram_bist. Instance A: DEPTH=16, ERRW=16 with a stuck-bit RAM
// model. Instance B: DEPTH=12, ERRW=2 with an optional read-corrupting RAM model.
module tb_simple_ram_bist;

    localparam logic [31:0] SEED = 32'hA5A5_5A5A;
    localparam int DA = 16;
    localparam int DB = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_a = 1'b0;
    logic start_b = 1'b0;

    logic        a_busy, a_done, a_pass, a_wen, a_cen;
    logic [15:0] a_errcnt;
    logic [3:0]  a_faddr, a_addr;
    logic [31:0] a_fdata, a_dati;
    logic [31:0] a_dato = '0;

    logic        b_busy, b_done, b_pass, b_wen, b_cen;
    logic [1:0]  b_errcnt;
    logic [3:0]  b_faddr, b_addr;
    logic [31:0] b_fdata, b_dati;
    logic [31:0] b_dato = '0;

    simple_ram_bist #(.DATAW(32), .DEPTH(DA), .SEED(SEED), .ERRW(16)) dut_a (
        .CLK(clk), .RST(rst), .START(start_a), .BUSY(a_busy), .DONE(a_done), .PASS(a_pass),
        .ERRCNT(a_errcnt), .FADDR(a_faddr), .FDATA(a_fdata), .M_WEN(a_wen), .M_CEN(a_cen),
        .M_ADDR(a_addr), .M_DATi(a_dati), .M_DATo(a_dato)
    );

    simple_ram_bist #(.DATAW(32), .DEPTH(DB), .SEED(SEED), .ERRW(2)) dut_b (
        .CLK(clk), .RST(rst), .START(start_b), .BUSY(b_busy), .DONE(b_done), .PASS(b_pass),
        .ERRCNT(b_errcnt), .FADDR(b_faddr), .FDATA(b_fdata), .M_WEN(b_wen), .M_CEN(b_cen),
        .M_ADDR(b_addr), .M_DATi(b_dati), .M_DATo(b_dato)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM models
    logic [31:0] mem_a [16];
    logic [31:0] sa0_a [16];
    logic [31:0] sa1_a [16];
    logic [31:0] mem_b [16];
    logic [31:0] corrupt_b = '0;

    always @(posedge clk) begin
        if (a_cen) begin
            if (a_wen) mem_a[a_addr] <= (a_dati & ~sa0_a[a_addr]) | sa1_a[a_addr];
            else       a_dato <= mem_a[a_addr];
        end
        if (b_cen) begin
            if (b_wen) mem_b[b_addr] <= b_dati;
            else       b_dato <= mem_b[b_addr] ^ corrupt_b;
        end
    end

    typedef struct {
        logic        wen;
        logic [3:0]  addr;
        logic [31:0] data;
        int          ph;
    } op_t;

    typedef struct {
        int          errcnt;
        int          faddr;
        logic [31:0] fdata;
        logic        pass;
        int          lat;
    } res_t;

    op_t  ops_a [$];
    res_t res_a [$];
    res_t res_b [$];

    int n_checks = 0;
    int n_errors = 0;
    int e0_a = 0;
    int e0_b = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: event not expected by the scoreboard", name);
    endtask

    // ---- Reference model: whole-test outcome from the pattern rules ----
    function automatic logic [31:0] pat(input int a);
        return SEED ^ 32'(a);
    endfunction

    function automatic logic [31:0] ram_read(input bit is_b, input int a, input logic [31:0] w);
        if (is_b) return w ^ corrupt_b;
        return (w & ~sa0_a[a]) | sa1_a[a];
    endfunction

    function automatic res_t ref_result(input bit is_b, input int depth, input int errmax);
        res_t r;
        int n;
        bit found;
        n = 0;
        found = 1'b0;
        r.faddr = 0;
        r.fdata = '0;
        for (int ph = 0; ph < 2; ph++) begin
            for (int a = 0; a < depth; a++) begin
                logic [31:0] w;
                logic [31:0] got;
                w = (ph == 0) ? pat(a) : ~pat(a);
                got = ram_read(is_b, a, w);
                if (got != w) begin
                    n++;
                    if (!found) begin
                        found = 1'b1;
                        r.faddr = a;
                        r.fdata = got;
                    end
                end
            end
        end
        r.errcnt = (n > errmax) ? errmax : n;
        r.pass   = (n == 0);
        r.lat    = 4 * depth + 2;
        return r;
    endfunction

    task automatic push_ops_a();
        op_t op;
        for (int ph = 0; ph < 4; ph++) begin
            for (int a = 0; a < DA; a++) begin
                op.wen  = (ph % 2 == 0);
                op.addr = 4'(a);
                op.data = (ph < 2) ? pat(a) : ~pat(a);
                op.ph   = ph;
                ops_a.push_back(op);
            end
        end
    endtask

    // ---- Monitors ----
    op_t  mon_op_a;
    res_t mon_res_a;
    res_t mon_res_b;
    logic a_done_prev = 1'b0;
    logic b_done_prev = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            a_done_prev = 1'b0;
        end else begin
            if (a_wen) chk("a_wen_implies_cen", a_cen, 1);
            if (a_cen) begin
                if (ops_a.size() == 0) begin
                    flag("a_extra_ram_op");
                end else begin
                    mon_op_a = ops_a.pop_front();
                    chk("a_ram_op", {a_wen, a_addr, a_wen ? a_dati : 32'h0},
                        {mon_op_a.wen, mon_op_a.addr, mon_op_a.wen ? mon_op_a.data : 32'h0});
                    if (a_wen && a_addr == 4'd5 && mon_op_a.ph == 0)
                        chk("a_wdata_ph0_a5", a_dati, 32'hA5A5_5A5F);
                    if (a_wen && a_addr == 4'd5 && mon_op_a.ph == 2)
                        chk("a_wdata_ph2_a5", a_dati, 32'h5A5A_A5A0);
                end
            end
            if (a_done && !a_done_prev) begin
                if (res_a.size() == 0) begin
                    flag("a_unexpected_done");
                end else begin
                    mon_res_a = res_a.pop_front();
                    chk("a_done_latency", cyc - e0_a, mon_res_a.lat);
                    chk("a_errcnt", a_errcnt, mon_res_a.errcnt);
                    chk("a_faddr", a_faddr, mon_res_a.faddr);
                    chk("a_fdata", a_fdata, mon_res_a.fdata);
                    chk("a_pass", a_pass, mon_res_a.pass);
                    chk("a_busy_at_done", a_busy, 0);
                    chk("a_ops_consumed", ops_a.size(), 0);
                end
            end
            a_done_prev = a_done;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            b_done_prev = 1'b0;
        end else begin
            if (b_cen) chk("b_addr_in_range", b_addr <= 4'd11, 1);
            if (b_done && !b_done_prev) begin
                if (res_b.size() == 0) begin
                    flag("b_unexpected_done");
                end else begin
                    mon_res_b = res_b.pop_front();
                    chk("b_done_latency", cyc - e0_b, mon_res_b.lat);
                    chk("b_errcnt", b_errcnt, mon_res_b.errcnt);
                    chk("b_faddr", b_faddr, mon_res_b.faddr);
                    chk("b_fdata", b_fdata, mon_res_b.fdata);
                    chk("b_pass", b_pass, mon_res_b.pass);
                end
            end
            b_done_prev = b_done;
        end
    end

    // ---- Stimulus ----
    task automatic clear_faults();
        for (int i = 0; i < 16; i++) begin
            sa0_a[i] = '0;
            sa1_a[i] = '0;
        end
    endtask

    task automatic wait_done(input bit is_b, input int limit);
        int k;
        k = 0;
        while (!(is_b ? b_done : a_done) && k < limit) begin
            @(negedge clk);
            k++;
        end
        chk(is_b ? "b_done_within_budget" : "a_done_within_budget", is_b ? b_done : a_done, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic run_a();
        @(negedge clk);
        push_ops_a();
        res_a.push_back(ref_result(1'b0, DA, 65535));
        start_a = 1'b1;
        @(posedge clk);
        #1;
        e0_a = cyc;
        start_a = 1'b0;
        wait_done(1'b0, 200);
    endtask

    task automatic run_b();
        @(negedge clk);
        res_b.push_back(ref_result(1'b1, DB, 3));
        start_b = 1'b1;
        @(posedge clk);
        #1;
        e0_b = cyc;
        start_b = 1'b0;
        wait_done(1'b1, 200);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int nf;
        int fa;
        int fb;
        clear_faults();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("a_reset_state", {a_busy, a_done, a_pass, a_errcnt, a_faddr, a_wen, a_cen, a_addr}, 0);
        chk("a_reset_data", {a_fdata, a_dati}, 0);
        chk("b_reset_state", {b_busy, b_done, b_pass, b_errcnt, b_wen, b_cen, b_addr}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Healthy RAM
        run_a();

        // Bit 3 of address 5 stuck at 0: only the phase-0 read fails
        clear_faults();
        sa0_a[5][3] = 1'b1;
        run_a();
        chk("a_fdata_stuck_a5", a_fdata, 32'hA5A5_5A57);
        chk("a_errcnt_stuck_a5", a_errcnt, 1);

        // Stuck bits at 3 and at the last address (compared in the drain cycle)
        clear_faults();
        sa0_a[3][0] = 1'b1;
        sa0_a[15][0] = 1'b1;
        run_a();
        chk("a_errcnt_two_faults", a_errcnt, 2);
        chk("a_faddr_first_held", a_faddr, 3);

        // START while busy ignored; reset mid-test aborts at once
        clear_faults();
        @(negedge clk);
        push_ops_a();
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        chk("a_busy_after_ignored_start", a_busy, 1);
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("a_abort_wen", a_wen, 0);
        chk("a_abort_cen", a_cen, 0);
        chk("a_abort_busy", a_busy, 0);
        ops_a.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("a_after_abort_done", {a_done, a_pass, a_errcnt}, 0);
        run_a();

        // Randomized stuck-bit faults
        for (int r = 0; r < 5; r++) begin
            clear_faults();
            nf = $urandom_range(0, 3);
            for (int f = 0; f < nf; f++) begin
                fa = $urandom_range(0, 15);
                fb = $urandom_range(0, 31);
                if ($urandom_range(0, 1) == 1) sa0_a[fa][fb] = 1'b1;
                else                           sa1_a[fa][fb] = 1'b1;
            end
            run_a();
        end

        // Non-power-of-2 depth, healthy then every read corrupted (saturation)
        corrupt_b = '0;
        run_b();
        corrupt_b = $urandom | 32'h1;
        run_b();
        chk("b_errcnt_saturated", b_errcnt, 3);

        chk("a_results_drained", res_a.size(), 0);
        chk("b_results_drained", res_b.size(), 0);
        chk("a_ops_drained", ops_a.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
